// File: rtl/pipeline_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int STALL_CNT_W = 16;

  // A32 NOP encoding, the bubble for IF/ID instruction payloads.
  localparam logic [31:0] ARM_NOP_INSN = 32'hE320_F000;

endpackage

// File: rtl/pipeline_stage_register_slot.sv
// One payload slot: WIDTH-bit register with load enable that resets to the bubble value.
module stage_slot #(
  parameter int                WIDTH     = 64,
  parameter logic [WIDTH-1:0]  NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Slot storage, cleared to the bubble on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= NOP_VALUE;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Pipeline stage register: valid/ready handshake, freeze, flush, optional skid slot
// and a saturating stall counter.
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  stage_state_e            state_q, state_d;
  logic [STALL_CNT_W-1:0]  stall_q, stall_d;
  logic [WIDTH-1:0]        main_q, main_d, skid_q, skid_d;
  logic                    main_load_s, skid_load_s;
  logic                    in_ready_s, out_valid_s, in_fire_s, out_fire_s;

  stage_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (main_load_s),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  generate
    if (SKID) begin : g_skid
      stage_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (skid_load_s),
        .d_i    (skid_d),
        .q_o    (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = NOP_VALUE;
    end
  endgenerate

  // Handshake qualification; in_ready is forced low while reset is held.
  always_comb begin
    out_valid_s = (state_q != ST_EMPTY) && !freeze;
    if (!rst) begin
      in_ready_s = 1'b0;
    end else if (SKID) begin
      in_ready_s = (state_q != ST_TWO) && !freeze;
    end else begin
      in_ready_s = ((state_q == ST_EMPTY) || out_ready) && !freeze;
    end
    in_fire_s  = in_valid && in_ready_s;
    out_fire_s = out_valid_s && out_ready;
  end

  // Next state and slot loads; flush overrides everything, including freeze.
  always_comb begin
    state_d     = state_q;
    main_load_s = 1'b0;
    main_d      = in_data;
    skid_load_s = 1'b0;
    skid_d      = in_data;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_load_s = 1'b1;
      main_d      = NOP_VALUE;
      skid_load_s = 1'b1;
      skid_d      = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d     = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_load_s = 1'b1;
          end else if (in_fire_s) begin
            // Only reachable with SKID=1: without skid, in_fire implies out_fire here.
            state_d     = ST_TWO;
            skid_load_s = 1'b1;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_d     = ST_ONE;
            main_load_s = 1'b1;
            main_d      = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles where a visible entry is refused downstream.
  always_comb begin
    if (out_valid_s && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // Control state and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      stall_q <= {STALL_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_s;
  assign out_data     = (state_q != ST_EMPTY) ? main_q : NOP_VALUE;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed self-checking bench: a SKID=1 instance and a SKID=0 instance sharing clock and reset.
module tb_pipeline_stage_register;

  logic        clk;
  logic        rst;
  logic        freeze, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] stall_cycles;

  logic        in_valid0, out_ready0;
  logic [63:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [63:0] out_data0;
  logic [15:0] stall_cycles0;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_stage_register #(.WIDTH(64), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cycles(stall_cycles)
  );

  pipeline_stage_register #(.WIDTH(64), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .freeze(1'b0), .flush(1'b0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .stall_cycles(stall_cycles0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_data0 = 64'h0; out_ready0 = 1'b0;

    // Reset state
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_stall", {48'd0, stall_cycles}, 64'd0);
    rst = 1'b1;
    #1;
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    cyc();

    // Stream 1,2,3 with out_ready=1
    drive(1'b1, 64'h1, 1'b1);
    check_eq("st_in_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    drive(1'b1, 64'h2, 1'b1);
    check_eq("st_d1", out_data, 64'h1);
    check_eq("st_v1", {63'd0, out_valid}, 64'd1);
    cyc();
    drive(1'b1, 64'h3, 1'b1);
    check_eq("st_d2", out_data, 64'h2);
    cyc();
    drive(1'b0, 64'h0, 1'b1);
    check_eq("st_d3", out_data, 64'h3);
    cyc();
    check_eq("st_empty", {63'd0, out_valid}, 64'd0);
    check_eq("st_stall", {48'd0, stall_cycles}, 64'd0);

    // Backpressure into skid: A, B, C
    drive(1'b1, 64'hA, 1'b1);
    cyc();
    drive(1'b1, 64'hB, 1'b0);
    check_eq("bp_dA", out_data, 64'hA);
    check_eq("bp_rdy_one", {63'd0, in_ready}, 64'd1);
    cyc();
    drive(1'b1, 64'hC, 1'b0);
    check_eq("bp_rdy_two", {63'd0, in_ready}, 64'd0);
    check_eq("bp_hold_A", out_data, 64'hA);
    cyc();
    drive(1'b1, 64'hC, 1'b1);
    check_eq("bp_rdy_two_or", {63'd0, in_ready}, 64'd0);
    check_eq("bp_out_A", out_data, 64'hA);
    cyc();
    drive(1'b1, 64'hC, 1'b1);
    check_eq("bp_out_B", out_data, 64'hB);
    check_eq("bp_rdy_back", {63'd0, in_ready}, 64'd1);
    cyc();
    drive(1'b0, 64'h0, 1'b1);
    check_eq("bp_out_C", out_data, 64'hC);
    cyc();
    check_eq("bp_empty", {63'd0, out_valid}, 64'd0);
    check_eq("bp_stall", {48'd0, stall_cycles}, 64'd2);

    // Flush while full (TWO holding 0x10, 0x11), 0x12 presented in flush cycle
    drive(1'b1, 64'h10, 1'b0);
    cyc();
    drive(1'b1, 64'h11, 1'b0);
    cyc();
    check_eq("fl_two", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 64'h12, 1'b1);
    cyc();
    flush = 1'b0;
    drive(1'b0, 64'h0, 1'b1);
    check_eq("fl_valid", {63'd0, out_valid}, 64'd0);
    check_eq("fl_data", out_data, 64'd0);
    check_eq("fl_rdy", {63'd0, in_ready}, 64'd1);
    cyc();
    check_eq("fl_no12", {63'd0, out_valid}, 64'd0);
    check_eq("fl_stall", {48'd0, stall_cycles}, 64'd3);

    // Freeze with 0x20 held
    drive(1'b1, 64'h20, 1'b0);
    cyc();
    freeze = 1'b1;
    drive(1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("fz_valid%0d", i), {63'd0, out_valid}, 64'd0);
      check_eq($sformatf("fz_rdy%0d", i), {63'd0, in_ready}, 64'd0);
      cyc();
    end
    freeze = 1'b0;
    #1;
    check_eq("fz_rel_valid", {63'd0, out_valid}, 64'd1);
    check_eq("fz_rel_data", out_data, 64'h20);
    cyc();
    check_eq("fz_once", {63'd0, out_valid}, 64'd0);
    check_eq("fz_stall", {48'd0, stall_cycles}, 64'd3);

    // Async reset while in TWO
    drive(1'b1, 64'h30, 1'b0);
    cyc();
    drive(1'b1, 64'h31, 1'b0);
    cyc();
    drive(1'b0, 64'h0, 1'b0);
    check_eq("ar_two_valid", {63'd0, out_valid}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("ar_valid", {63'd0, out_valid}, 64'd0);
    check_eq("ar_data", out_data, 64'd0);
    check_eq("ar_rdy", {63'd0, in_ready}, 64'd0);
    check_eq("ar_stall", {48'd0, stall_cycles}, 64'd0);
    rst = 1'b1;
    #1;
    check_eq("ar_rel_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("ar_rel_valid", {63'd0, out_valid}, 64'd0);
    cyc();

    // SKID=0 instance, out_ready toggling
    in_valid0 = 1'b1; in_data0 = 64'h40; out_ready0 = 1'b1; #1;
    check_eq("s0_rdy_empty", {63'd0, in_ready0}, 64'd1);
    cyc();
    in_data0 = 64'h41; out_ready0 = 1'b0; #1;
    check_eq("s0_rdy_lo1", {63'd0, in_ready0}, 64'd0);
    check_eq("s0_d40", out_data0, 64'h40);
    cyc();
    out_ready0 = 1'b1; #1;
    check_eq("s0_rdy_hi1", {63'd0, in_ready0}, 64'd1);
    check_eq("s0_d40b", out_data0, 64'h40);
    cyc();
    in_data0 = 64'h42; out_ready0 = 1'b0; #1;
    check_eq("s0_rdy_lo2", {63'd0, in_ready0}, 64'd0);
    check_eq("s0_d41", out_data0, 64'h41);
    cyc();
    out_ready0 = 1'b1; #1;
    check_eq("s0_rdy_hi2", {63'd0, in_ready0}, 64'd1);
    check_eq("s0_d41b", out_data0, 64'h41);
    cyc();
    in_valid0 = 1'b0; out_ready0 = 1'b0; #1;
    check_eq("s0_d42", out_data0, 64'h42);
    check_eq("s0_rdy_lo3", {63'd0, in_ready0}, 64'd0);
    cyc();
    out_ready0 = 1'b1; #1;
    check_eq("s0_d42b", out_data0, 64'h42);
    check_eq("s0_rdy_hi3", {63'd0, in_ready0}, 64'd1);
    cyc();
    check_eq("s0_empty", {63'd0, out_valid0}, 64'd0);
    check_eq("s0_stall", {48'd0, stall_cycles0}, 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Parametrised pipeline stage register with a valid/ready handshake, freeze, flush, and an optional 2-entry skid buffer. It is the generic successor for every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload, inserts a bubble (NOP payload) on flush, and breaks the combinational ready path when skid mode is enabled. A saturating stall counter supports performance monitoring.

## Interface
- WIDTH, 64, payload width in bits (e.g. {PC, Instruction} = 64).
- NOP_VALUE, {WIDTH{1'b0}}, payload driven on out_data whenever the stage holds no valid entry.
- SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single register (in_ready combinational from out_ready).
- clk  input  1  single clock, rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- freeze  input  1  hazard stall; holds all state, blocks both handshakes.
- flush  input  1  synchronous squash of all held entries; branch-taken kill.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head this cycle.
- out_data  output  WIDTH  head payload, or NOP_VALUE when empty.
- stall_cycles  output  16  saturating count of out_valid && !out_ready cycles.

## Operation
- Handshake events: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready. Both events are impossible while freeze = 1.
- States (SKID=1): EMPTY, ONE (main slot full), TWO (main and skid slots full).
  - EMPTY: on in_fire, go to ONE and load main.
  - ONE: in_fire && out_fire, stay in ONE and load main. in_fire only, go to TWO and load skid. out_fire only, go to EMPTY.
  - TWO: on out_fire, go to ONE and set main <= skid. in_ready = 0.
- SKID=1: in_ready = (state != TWO) && !freeze. There is no path from out_ready to in_ready.
- SKID=0: only EMPTY and ONE exist. in_ready = (state == EMPTY || out_ready) && !freeze.
- out_valid = (state != EMPTY) && !freeze. During freeze, out_valid may fall while an entry is held. This is the only permitted exception to the valid-stability rule.
- out_data = main slot when state != EMPTY, else NOP_VALUE. Payload is never altered in flight.
- flush has priority over everything, including freeze and concurrent in_fire/out_fire.
  - Next state is EMPTY and both slots are loaded with NOP_VALUE.
  - Any entry presented on in_data during the flush cycle is discarded, even if in_ready was 1.
- stall_cycles increments when out_valid && !out_ready, saturates at 16'hFFFF, and is cleared only by reset. Frozen cycles are not counted.
- Ordering is strictly FIFO. No entry is lost or duplicated unless a flush occurs.

## Timing
- Reset (rst = 0, asynchronous): state EMPTY, slots = NOP_VALUE, stall_cycles = 0.
  - Outputs while in reset: out_valid = 0, out_data = NOP_VALUE, in_ready = 0.
  - After reset deasserts: in_ready = !freeze.
- Reset asserted mid-operation drops all held entries immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N appears on out_valid/out_data after edge N and can leave at edge N+1 at the earliest.
- Throughput: 1 entry/cycle sustained in both modes while out_ready = 1.
- SKID=1, out_ready deasserting with the stage full: one more entry is absorbed into skid, then in_ready falls the next cycle.
- Flush cycle: out_valid reads 0 from the cycle after the flush edge. in_ready is unaffected by flush except through state.
- Freeze + flush in the same cycle: the flush takes effect and freeze suppresses nothing.

## Structure
- Shared package pipeline_pkg holds:
  - the state typedef (EMPTY/ONE/TWO, 2 bits);
  - STALL_CNT_W = 16;
  - the default NOP constant for the instruction payload (ARM NOP encoding, reused by IF/ID instances).
- Sub-module stage_slot: a WIDTH-bit register with async active-low reset to NOP_VALUE, plus load enable. It is instantiated twice (main and skid); skid is generated only when SKID = 1.
- Control FSM, handshake logic and stall counter live in the top module.

## Test plan
- Reset then stream: reset, then in_valid = 1 with data 0x1, 0x2, 0x3 on consecutive cycles and out_ready = 1 -> out_data is 0x1, 0x2, 0x3 on the following cycles, no bubbles, stall_cycles = 0.
- Backpressure (SKID=1):
  - Stimulus: stream 0xA, 0xB, 0xC; drop out_ready after 0xA is presented.
  - Required: 0xB is absorbed into skid and in_ready = 0 next cycle.
  - Then raise out_ready: output order is 0xA, 0xB, 0xC, and stall_cycles equals the number of held cycles.
- Flush while full: state TWO holding 0x10 and 0x11, flush = 1 with in_valid = 1 and data 0x12 -> next cycle out_valid = 0, out_data = NOP_VALUE, and 0x12 never appears.
- Freeze: hold freeze = 1 for 3 cycles with entry 0x20 held and out_ready = 1 -> out_valid = 0 and in_ready = 0 throughout. After release, 0x20 emerges exactly once.
- Async reset mid-stream: assert rst = 0 between edges while in state TWO -> out_valid = 0 and out_data = NOP_VALUE immediately. stall_cycles = 0 and state is EMPTY after release.
- SKID=0 instance: out_ready toggles 1/0 each cycle during a stream -> in_ready tracks out_ready combinationally, with no loss or reordering.
